result_pipe: RTL and testbench
==============================

# result_pipe

Producer side of the forwarding interface. Holds the EX/MEM and MEM/WB pipeline registers and drives the `EX_MEM_*` and `MEM_WB_*` signals that the forwarding unit and register-file write port consume. It also detects load-use hazards for the ID stage and absorbs data-memory stalls and branch flushes, including flushes that arrive during a stall. It sits between the EX stage, the data memory and the register file.

## Interface
- `DATA_W`, default 32: datapath width.
- `REG_W`, default 5: register-specifier width.
- `CNT_W`, default 32: retire counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  EX stage holds a real instruction.
- `ex_reg_write`  in  1  EX instruction writes a register.
- `ex_mem_read`  in  1  EX instruction is a load.
- `ex_dest_reg`  in  REG_W  EX destination register.
- `ex_alu_result`  in  DATA_W  EX ALU result (the load address for loads).
- `mem_rdata`  in  DATA_W  data-memory read data for the instruction in EX/MEM, valid in the same cycle.
- `mem_stall`  in  1  data memory not ready.
- `flush`  in  1  kill the instruction currently in EX.
- `id_rs`, `id_rt`  in  REG_W  ID-stage source specifiers.
- `EX_MEM_RegWrite`  out  1  EX/MEM entry will write a register.
- `EX_MEM_dest_reg`  out  REG_W  EX/MEM destination register.
- `EX_MEM_result`  out  DATA_W  EX/MEM ALU result.
- `MEM_WB_RegWrite`  out  1  MEM/WB entry writes a register; also the register-file write enable.
- `MEM_WB_dest_reg`  out  REG_W  MEM/WB destination; also the register-file write address.
- `MEM_WB_result`  out  DATA_W  writeback data.
- `pipe_hold`  out  1  upstream stages must freeze.
- `load_use_stall`  out  1  ID must insert one bubble.
- `retire_count`  out  CNT_W  count of instructions that have entered MEM/WB.

## Operation
- EX/MEM state: `valid`, `reg_write`, `mem_read`, `dest`, `result`. MEM/WB state: `reg_write`, `dest`, `result`. Also one `flush_pending` bit.
- `EX_MEM_RegWrite` = `valid` & `reg_write` & (`dest` != 0). `MEM_WB_RegWrite` is gated the same way, so register 0 is never reported as written.
- `pipe_hold` = `mem_stall` (combinational).
- `load_use_stall` = `ex_valid` & `ex_mem_read` & `ex_reg_write` & (`ex_dest_reg` != 0) & (`ex_dest_reg` == `id_rs` | `ex_dest_reg` == `id_rt`) & !`flush` & !`flush_pending`. This is combinational.
- Edge with `mem_stall`=1:
  - EX/MEM holds all fields.
  - MEM/WB loads a bubble: `reg_write`=0, `dest`=0, `result` held.
  - If `flush`=1, set `flush_pending`.
  - `retire_count` unchanged.
- Edge with `mem_stall`=0:
  - MEM/WB takes EX/MEM `reg_write`&`valid` and `dest`. Its `result` = `mem_rdata` if EX/MEM `mem_read`, else EX/MEM `result`.
  - If `flush` or `flush_pending` or !`ex_valid`, EX/MEM takes a bubble (all fields 0). Otherwise it takes the `ex_*` inputs.
  - `flush_pending` clears.
  - If EX/MEM was `valid`, `retire_count` increments, wrapping modulo 2^CNT_W.
- A load in EX/MEM reports `EX_MEM_RegWrite`=1 with the address on `EX_MEM_result`. The `load_use_stall` bubble guarantees no consumer is in EX at that point.
- Simultaneous `flush` and `load_use_stall` conditions: the flush wins and `load_use_stall`=0.

## Timing
- Reset (asynchronous assert, synchronous release on the next edge): every register and `flush_pending` go to 0. All outputs are 0 while `reset_n`=0.
- Latency: EX inputs appear on `EX_MEM_*` one edge later and on `MEM_WB_*` two edges later, plus one edge for each `mem_stall` cycle in between.
- `pipe_hold` and `load_use_stall` have zero-cycle latency.
- A reset asserted mid-stall discards the EX/MEM, MEM/WB and pending-flush contents; nothing retires.
- `retire_count` wraps from 2^CNT_W-1 to 0 with no flag.

## Test plan
- Back-to-back ALU ops: dest 3 result 0x11, then dest 4 result 0x22. Required: edge 1 gives `EX_MEM_dest_reg`=3; edge 2 gives `MEM_WB_dest_reg`=3, `MEM_WB_result`=0x11 and `EX_MEM_dest_reg`=4; `retire_count`=1 after edge 2 and 2 after edge 3.
- Load dest 5 in EX with `id_rt`=5: `load_use_stall`=1 in the same cycle. With `mem_rdata`=0xCAFE on the next cycle, `MEM_WB_result`=0xCAFE and `MEM_WB_RegWrite`=1 one edge later.
- Dest 0 with `ex_reg_write`=1: `EX_MEM_RegWrite`=0 and `MEM_WB_RegWrite`=0 throughout; the retire count still increments.
- `mem_stall` held 3 cycles with a flush pulsed on stall cycle 2: EX/MEM held; MEM/WB shows 3 bubbles; after release, EX/MEM is a bubble even with `ex_valid`=1, then normal flow resumes.
- Flush with a load-use match in the same cycle: `load_use_stall`=0 and EX/MEM takes a bubble on the edge.
- `reset_n` dropped mid-stall with a valid EX/MEM entry: all outputs 0 immediately, and `retire_count`=0 after release.

Source files
------------

// File: rtl/result_pipe.sv
// result_pipe: EX/MEM and MEM/WB pipeline registers feeding the forwarding
// unit and the register-file write port. Also flags load-use hazards to ID,
// freezes on data-memory stalls and absorbs branch flushes, remembering a
// flush that lands during a stall until the stall releases.
module result_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_dest_reg,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  input  logic              flush,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  output logic              EX_MEM_RegWrite,
  output logic [REG_W-1:0]  EX_MEM_dest_reg,
  output logic [DATA_W-1:0] EX_MEM_result,
  output logic              MEM_WB_RegWrite,
  output logic [REG_W-1:0]  MEM_WB_dest_reg,
  output logic [DATA_W-1:0] MEM_WB_result,
  output logic              pipe_hold,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  retire_count
);

  logic              exMemValid_q, exMemValid_d;
  logic              exMemRegWrite_q, exMemRegWrite_d;
  logic              exMemMemRead_q, exMemMemRead_d;
  logic [REG_W-1:0]  exMemDest_q, exMemDest_d;
  logic [DATA_W-1:0] exMemResult_q, exMemResult_d;
  logic              memWbRegWrite_q, memWbRegWrite_d;
  logic [REG_W-1:0]  memWbDest_q, memWbDest_d;
  logic [DATA_W-1:0] memWbResult_q, memWbResult_d;
  logic              flushPending_q, flushPending_d;
  logic [CNT_W-1:0]  retireCount_q, retireCount_d;

  logic exDestMatch;

  // Register 0 is hardwired, so a write to it is never advertised.
  assign EX_MEM_RegWrite = exMemValid_q & exMemRegWrite_q & (exMemDest_q != '0);
  assign EX_MEM_dest_reg = exMemDest_q;
  assign EX_MEM_result   = exMemResult_q;
  assign MEM_WB_RegWrite = memWbRegWrite_q & (memWbDest_q != '0);
  assign MEM_WB_dest_reg = memWbDest_q;
  assign MEM_WB_result   = memWbResult_q;
  assign retire_count    = retireCount_q;

  // Hold and hazard flags are combinational but forced low during reset so
  // that every output reads zero while reset_n is asserted.
  assign exDestMatch    = (ex_dest_reg == id_rs) | (ex_dest_reg == id_rt);
  assign pipe_hold      = reset_n & mem_stall;
  assign load_use_stall = reset_n & ex_valid & ex_mem_read & ex_reg_write &
                          (ex_dest_reg != '0) & exDestMatch &
                          ~flush & ~flushPending_q;

  // Next-state logic: a stall freezes EX/MEM and drains a bubble into MEM/WB;
  // otherwise both stages advance and a live or pending flush kills EX.
  always_comb begin
    exMemValid_d    = exMemValid_q;
    exMemRegWrite_d = exMemRegWrite_q;
    exMemMemRead_d  = exMemMemRead_q;
    exMemDest_d     = exMemDest_q;
    exMemResult_d   = exMemResult_q;
    memWbRegWrite_d = memWbRegWrite_q;
    memWbDest_d     = memWbDest_q;
    memWbResult_d   = memWbResult_q;
    flushPending_d  = flushPending_q;
    retireCount_d   = retireCount_q;
    if (mem_stall) begin
      memWbRegWrite_d = 1'b0;
      memWbDest_d     = '0;
      if (flush) flushPending_d = 1'b1;
    end else begin
      memWbRegWrite_d = exMemRegWrite_q & exMemValid_q;
      memWbDest_d     = exMemDest_q;
      memWbResult_d   = exMemMemRead_q ? mem_rdata : exMemResult_q;
      if (flush || flushPending_q || !ex_valid) begin
        exMemValid_d    = 1'b0;
        exMemRegWrite_d = 1'b0;
        exMemMemRead_d  = 1'b0;
        exMemDest_d     = '0;
        exMemResult_d   = '0;
      end else begin
        exMemValid_d    = 1'b1;
        exMemRegWrite_d = ex_reg_write;
        exMemMemRead_d  = ex_mem_read;
        exMemDest_d     = ex_dest_reg;
        exMemResult_d   = ex_alu_result;
      end
      flushPending_d = 1'b0;
      if (exMemValid_q) retireCount_d = retireCount_q + 1'b1;
    end
  end

  // Pipeline state registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exMemValid_q    <= 1'b0;
      exMemRegWrite_q <= 1'b0;
      exMemMemRead_q  <= 1'b0;
      exMemDest_q     <= '0;
      exMemResult_q   <= '0;
      memWbRegWrite_q <= 1'b0;
      memWbDest_q     <= '0;
      memWbResult_q   <= '0;
      flushPending_q  <= 1'b0;
      retireCount_q   <= '0;
    end else begin
      exMemValid_q    <= exMemValid_d;
      exMemRegWrite_q <= exMemRegWrite_d;
      exMemMemRead_q  <= exMemMemRead_d;
      exMemDest_q     <= exMemDest_d;
      exMemResult_q   <= exMemResult_d;
      memWbRegWrite_q <= memWbRegWrite_d;
      memWbDest_q     <= memWbDest_d;
      memWbResult_q   <= memWbResult_d;
      flushPending_q  <= flushPending_d;
      retireCount_q   <= retireCount_d;
    end
  end

endmodule

// File: tb/tb_result_pipe.sv
// Directed bench for result_pipe: hand-computed expectations checked with
// immediate assertions after each clock edge or input change.
module tb_result_pipe;

  logic        clk;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  ex_dest_reg;
  logic [31:0] ex_alu_result;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        flush;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        EX_MEM_RegWrite;
  logic [4:0]  EX_MEM_dest_reg;
  logic [31:0] EX_MEM_result;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_dest_reg;
  logic [31:0] MEM_WB_result;
  logic        pipe_hold;
  logic        load_use_stall;
  logic [31:0] retire_count;

  int vectors;
  int miscompares;

  result_pipe #(.DATA_W(32), .REG_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_dest_reg(ex_dest_reg), .ex_alu_result(ex_alu_result),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_dest_reg(EX_MEM_dest_reg),
    .EX_MEM_result(EX_MEM_result),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_dest_reg(MEM_WB_dest_reg),
    .MEM_WB_result(MEM_WB_result),
    .pipe_hold(pipe_hold), .load_use_stall(load_use_stall),
    .retire_count(retire_count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench cannot hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic setEx(input logic v, input logic rw, input logic mr,
                       input logic [4:0] d, input logic [31:0] r);
    ex_valid = v; ex_reg_write = rw; ex_mem_read = mr;
    ex_dest_reg = d; ex_alu_result = r;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0;
    setEx(0, 0, 0, 0, 0);
    mem_rdata = 0; mem_stall = 1'b1; flush = 1'b0; id_rs = 0; id_rt = 0;

    // Reset state, with a stall request pending to check output gating
    #12;
    checkOutput("rst_pipe_hold", pipe_hold, 0);
    checkOutput("rst_exmem_rw", EX_MEM_RegWrite, 0);
    checkOutput("rst_memwb_rw", MEM_WB_RegWrite, 0);
    checkOutput("rst_retire", retire_count, 0);
    mem_stall = 1'b0;
    reset_n = 1'b1;
    applyStimulus();

    // Back-to-back ALU ops
    setEx(1, 1, 0, 3, 32'h11);
    applyStimulus();
    checkOutput("alu1_exmem_dest", EX_MEM_dest_reg, 3);
    checkOutput("alu1_exmem_rw", EX_MEM_RegWrite, 1);
    checkOutput("alu1_exmem_res", EX_MEM_result, 32'h11);
    checkOutput("alu1_retire", retire_count, 0);
    setEx(1, 1, 0, 4, 32'h22);
    applyStimulus();
    checkOutput("alu2_memwb_dest", MEM_WB_dest_reg, 3);
    checkOutput("alu2_memwb_res", MEM_WB_result, 32'h11);
    checkOutput("alu2_memwb_rw", MEM_WB_RegWrite, 1);
    checkOutput("alu2_exmem_dest", EX_MEM_dest_reg, 4);
    checkOutput("alu2_retire", retire_count, 1);
    setEx(0, 0, 0, 0, 0);
    applyStimulus();
    checkOutput("alu3_retire", retire_count, 2);
    checkOutput("alu3_memwb_res", MEM_WB_result, 32'h22);
    checkOutput("alu3_exmem_rw", EX_MEM_RegWrite, 0);

    // Load-use hazard and load writeback
    setEx(1, 1, 1, 5, 32'h100);
    id_rt = 5;
    #1;
    checkOutput("lu_stall", load_use_stall, 1);
    id_rt = 6;
    #1;
    checkOutput("lu_nomatch", load_use_stall, 0);
    id_rt = 5;
    applyStimulus();
    checkOutput("ld_exmem_rw", EX_MEM_RegWrite, 1);
    checkOutput("ld_exmem_addr", EX_MEM_result, 32'h100);
    setEx(0, 0, 0, 0, 0);
    id_rt = 0;
    mem_rdata = 32'hCAFE;
    applyStimulus();
    checkOutput("ld_memwb_res", MEM_WB_result, 32'hCAFE);
    checkOutput("ld_memwb_rw", MEM_WB_RegWrite, 1);
    checkOutput("ld_memwb_dest", MEM_WB_dest_reg, 5);
    checkOutput("ld_retire", retire_count, 3);

    // Destination register 0
    setEx(1, 1, 0, 0, 32'h55);
    applyStimulus();
    checkOutput("r0_exmem_rw", EX_MEM_RegWrite, 0);
    checkOutput("r0_exmem_res", EX_MEM_result, 32'h55);
    setEx(0, 0, 0, 0, 0);
    applyStimulus();
    checkOutput("r0_memwb_rw", MEM_WB_RegWrite, 0);
    checkOutput("r0_memwb_res", MEM_WB_result, 32'h55);
    checkOutput("r0_retire", retire_count, 4);

    // Three-cycle stall with a flush on the second stall cycle
    setEx(1, 1, 0, 7, 32'h77);
    applyStimulus();
    checkOutput("st_pre_exmem_dest", EX_MEM_dest_reg, 7);
    setEx(1, 1, 0, 9, 32'h99);
    mem_stall = 1'b1;
    #1;
    checkOutput("st_pipe_hold", pipe_hold, 1);
    applyStimulus();
    checkOutput("st1_exmem_dest", EX_MEM_dest_reg, 7);
    checkOutput("st1_memwb_rw", MEM_WB_RegWrite, 0);
    checkOutput("st1_memwb_dest", MEM_WB_dest_reg, 0);
    checkOutput("st1_retire", retire_count, 4);
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0;
    checkOutput("st2_exmem_dest", EX_MEM_dest_reg, 7);
    checkOutput("st2_memwb_rw", MEM_WB_RegWrite, 0);
    applyStimulus();
    checkOutput("st3_exmem_dest", EX_MEM_dest_reg, 7);
    checkOutput("st3_memwb_dest", MEM_WB_dest_reg, 0);
    checkOutput("st3_retire", retire_count, 4);
    mem_stall = 1'b0;
    applyStimulus();
    checkOutput("rel_memwb_dest", MEM_WB_dest_reg, 7);
    checkOutput("rel_memwb_res", MEM_WB_result, 32'h77);
    checkOutput("rel_memwb_rw", MEM_WB_RegWrite, 1);
    checkOutput("rel_exmem_rw", EX_MEM_RegWrite, 0);
    checkOutput("rel_exmem_dest", EX_MEM_dest_reg, 0);
    checkOutput("rel_retire", retire_count, 5);
    applyStimulus();
    checkOutput("res_exmem_dest", EX_MEM_dest_reg, 9);
    checkOutput("res_exmem_rw", EX_MEM_RegWrite, 1);
    checkOutput("res_retire", retire_count, 5);
    setEx(0, 0, 0, 0, 0);
    applyStimulus();
    checkOutput("res_memwb_dest", MEM_WB_dest_reg, 9);
    checkOutput("res_retire2", retire_count, 6);

    // Flush together with a load-use match
    setEx(1, 1, 1, 6, 32'h200);
    id_rs = 6;
    #1;
    checkOutput("fl_lu_noflush", load_use_stall, 1);
    flush = 1'b1;
    #1;
    checkOutput("fl_lu_flush", load_use_stall, 0);
    applyStimulus();
    flush = 1'b0;
    setEx(0, 0, 0, 0, 0);
    id_rs = 0;
    checkOutput("fl_exmem_rw", EX_MEM_RegWrite, 0);
    checkOutput("fl_exmem_dest", EX_MEM_dest_reg, 0);
    checkOutput("fl_retire", retire_count, 6);

    // Reset asserted mid-stall with a valid EX/MEM entry
    setEx(1, 1, 0, 8, 32'h88);
    applyStimulus();
    checkOutput("rs_pre_exmem_dest", EX_MEM_dest_reg, 8);
    mem_stall = 1'b1;
    applyStimulus();
    checkOutput("rs_stall_exmem_dest", EX_MEM_dest_reg, 8);
    reset_n = 1'b0;
    #1;
    checkOutput("rs_exmem_rw", EX_MEM_RegWrite, 0);
    checkOutput("rs_exmem_dest", EX_MEM_dest_reg, 0);
    checkOutput("rs_exmem_res", EX_MEM_result, 0);
    checkOutput("rs_memwb_res", MEM_WB_result, 0);
    checkOutput("rs_memwb_dest", MEM_WB_dest_reg, 0);
    checkOutput("rs_pipe_hold", pipe_hold, 0);
    checkOutput("rs_retire", retire_count, 0);
    mem_stall = 1'b0;
    setEx(0, 0, 0, 0, 0);
    applyStimulus();
    reset_n = 1'b1;
    applyStimulus();
    checkOutput("rs_post_retire", retire_count, 0);
    checkOutput("rs_post_memwb_rw", MEM_WB_RegWrite, 0);
    checkOutput("rs_post_exmem_dest", EX_MEM_dest_reg, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
